// File: rtl/dcache_sram_nway.sv
// N-way set-associative data-cache storage array with true-LRU replacement
// and a dirty-line flush walk that offers every dirty line for writeback.
// Optional hit/miss statistics counters: define DCACHE_SRAM_STATS_EN.
module dcache_sram_nway #(
  parameter int unsigned SETS   = 16,
  parameter int unsigned WAYS   = 4,
  parameter int unsigned TAG_W  = 23,
  parameter int unsigned LINE_W = 256,
  localparam int unsigned SET_W = $clog2(SETS),
  localparam int unsigned WAY_W = $clog2(WAYS)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic              dirty_i,
  input  logic [SET_W-1:0]  addr_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              hit_o,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] data_o,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [SET_W-1:0]  wb_set_o,
  output logic [TAG_W-1:0]  wb_tag_o,
  output logic [LINE_W-1:0] wb_data_o,
  output logic              flush_done_o,
  input  logic              stats_clr_i,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
);

  localparam int unsigned IDX_W = SET_W + WAY_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WB,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  // Storage: per-set valid/dirty vectors, tags, lines and LRU ages
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAYS-1:0]   dirty_q [SETS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [WAY_W-1:0]  age_q   [SETS][WAYS];

  // Flush walk pointer: set-major, way-minor
  logic [IDX_W-1:0]  scan_idx_q;
  logic [SET_W-1:0]  scan_set;
  logic [WAY_W-1:0]  scan_way;
  logic              scan_last;
  logic              scan_rst;
  logic              scan_adv;
  logic              wb_clear;

  logic              hit_any;
  logic [WAY_W-1:0]  hit_way;
  logic              inv_any;
  logic [WAY_W-1:0]  inv_way;
  logic [WAY_W-1:0]  old_way;
  logic [WAY_W-1:0]  victim;
  logic [WAY_W-1:0]  sel_way;
  logic [WAY_W-1:0]  sel_age;
  logic              idle;
  logic              access_wr;
  logic              touch;

  assign scan_set  = scan_idx_q[IDX_W-1 -: SET_W];
  assign scan_way  = scan_idx_q[WAY_W-1:0];
  assign scan_last = &scan_idx_q;

  assign idle   = (state_q == ST_IDLE);
  assign busy_o = !idle;

  // Tag compare and victim choice for the addressed set (lowest index wins)
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    old_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (valid_q[addr_i][w] && (tag_q[addr_i][w] == tag_i) && !hit_any) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[addr_i][w] && !inv_any) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (age_q[addr_i][w] == WAY_W'(WAYS - 1)) begin
        old_way = WAY_W'(w);
      end
    end
    victim  = inv_any ? inv_way : old_way;
    sel_way = hit_any ? hit_way : victim;
  end

  assign sel_age = age_q[addr_i][sel_way];
  assign hit_o   = hit_any & idle;
  assign valid_o = valid_q[addr_i][sel_way];
  assign dirty_o = dirty_q[addr_i][sel_way];
  assign tag_o   = tag_q[addr_i][sel_way];
  assign data_o  = data_q[addr_i][sel_way];

  assign access_wr = enable_i & write_i & idle;
  assign touch     = access_wr | (enable_i & ~write_i & hit_o);

  // Flush FSM next-state and handshake outputs
  always_comb begin
    state_d      = state_q;
    scan_rst     = 1'b0;
    scan_adv     = 1'b0;
    wb_clear     = 1'b0;
    wb_valid_o   = 1'b0;
    wb_set_o     = '0;
    wb_tag_o     = '0;
    wb_data_o    = '0;
    flush_done_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (flush_i) begin
          state_d  = ST_SCAN;
          scan_rst = 1'b1;
        end
      end
      ST_SCAN: begin
        if (valid_q[scan_set][scan_way] && dirty_q[scan_set][scan_way]) begin
          state_d = ST_WB;
        end else if (scan_last) begin
          state_d = ST_DONE;
        end else begin
          scan_adv = 1'b1;
        end
      end
      ST_WB: begin
        wb_valid_o = 1'b1;
        wb_set_o   = scan_set;
        wb_tag_o   = tag_q[scan_set][scan_way];
        wb_data_o  = data_q[scan_set][scan_way];
        if (wb_ready_i) begin
          wb_clear = 1'b1;
          if (scan_last) begin
            state_d = ST_DONE;
          end else begin
            scan_adv = 1'b1;
            state_d  = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        flush_done_o = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and walk pointer registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      scan_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if (scan_rst) begin
        scan_idx_q <= '0;
      end else if (scan_adv) begin
        scan_idx_q <= scan_idx_q + IDX_W'(1);
      end
    end
  end

  // Array update: write/refill, LRU touch and writeback dirty clear
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
          age_q[s][w]  <= WAY_W'(w);
        end
      end
    end else begin
      if (access_wr) begin
        valid_q[addr_i][sel_way] <= 1'b1;
        dirty_q[addr_i][sel_way] <= hit_any ? (dirty_q[addr_i][sel_way] | dirty_i) : dirty_i;
        tag_q[addr_i][sel_way]   <= tag_i;
        data_q[addr_i][sel_way]  <= data_i;
      end
      if (touch) begin
        for (int unsigned w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == sel_way) begin
            age_q[addr_i][w] <= '0;
          end else if (age_q[addr_i][w] < sel_age) begin
            age_q[addr_i][w] <= age_q[addr_i][w] + WAY_W'(1);
          end
        end
      end
      if (wb_clear) begin
        dirty_q[scan_set][scan_way] <= 1'b0;
      end
    end
  end

`ifdef DCACHE_SRAM_STATS_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;
  logic        lookup;

  assign lookup = enable_i & ~write_i & idle;

  // Saturating lookup hit/miss counters; clear wins over increment
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (stats_clr_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (lookup) begin
      if (hit_o) begin
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  // Counters absent: stats_clr_i has no function in this build
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr_i;
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_sram_nway.sv
// Directed bench for dcache_sram_nway: table-driven lookup/write vectors
// followed by hand-written flush, reset and statistics sequences.
module tb_dcache_sram_nway;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable, write, dirty_in;
  logic [3:0]   addr;
  logic [22:0]  tag;
  logic [255:0] wdata;
  logic         hit, valid, dirty;
  logic [22:0]  tag_out;
  logic [255:0] data_out;
  logic         flush, busy, wb_valid, wb_ready;
  logic [3:0]   wb_set;
  logic [22:0]  wb_tag;
  logic [255:0] wb_data;
  logic         flush_done, stats_clr;
  logic [31:0]  hit_cnt, miss_cnt;

  int checks = 0;
  int errors = 0;

  int hs_cnt = 0;
  int done_cnt = 0;
  logic [3:0]  last_set = '0;
  logic [22:0] last_tag = '0;

  dcache_sram_nway #(.SETS(16), .WAYS(4), .TAG_W(23), .LINE_W(256)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .write_i(write),
    .dirty_i(dirty_in), .addr_i(addr), .tag_i(tag), .data_i(wdata),
    .hit_o(hit), .valid_o(valid), .dirty_o(dirty), .tag_o(tag_out),
    .data_o(data_out), .flush_i(flush), .busy_o(busy), .wb_valid_o(wb_valid),
    .wb_ready_i(wb_ready), .wb_set_o(wb_set), .wb_tag_o(wb_tag),
    .wb_data_o(wb_data), .flush_done_o(flush_done), .stats_clr_i(stats_clr),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;

  // Handshakes and done pulses, sampled late in the low phase
  always @(negedge clk) begin
    #2;
    if (rst_n && wb_valid && wb_ready) begin
      hs_cnt   <= hs_cnt + 1;
      last_set <= wb_set;
      last_tag <= wb_tag;
    end
    if (rst_n && flush_done) done_cnt <= done_cnt + 1;
  end

  function automatic logic [255:0] mkd(input logic [22:0] t, input logic [7:0] s);
    return {8{1'b1, s, t}};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         wr;
    logic [3:0]   set;
    logic [22:0]  tag;
    logic [255:0] data;
    logic         dirty;
    logic         e_hit;
    logic         e_valid;
    logic         e_dirty;
    logic [22:0]  e_tag;
    logic [255:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic wr, input logic [3:0] s, input logic [22:0] t,
                              input logic [7:0] salt, input logic d, input logic eh,
                              input logic ev, input logic ed, input logic [22:0] et,
                              input logic [255:0] edat);
    vec_t v;
    v.wr = wr; v.set = s; v.tag = t; v.data = mkd(t, salt); v.dirty = d;
    v.e_hit = eh; v.e_valid = ev; v.e_dirty = ed; v.e_tag = et; v.e_data = edat;
    return v;
  endfunction

  // Expected pre-edge outputs for a write into an empty way
  function automatic vec_t wr_empty(input logic [3:0] s, input logic [22:0] t,
                                    input logic [7:0] salt, input logic d);
    return mk(1'b1, s, t, salt, d, 1'b0, 1'b0, 1'b0, '0, '0);
  endfunction

  task automatic wait_wb(output int n);
    n = 1;
    while (!wb_valid && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    chk("wb_valid_seen", {255'd0, wb_valid}, 256'd1);
  endtask

  task automatic wait_idle(output int n);
    n = 1;
    while (busy && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("flush_terminates", {255'd0, busy}, 256'd0);
  endtask

  task automatic lookup_chk(input string name, input logic [3:0] s, input logic [22:0] t,
                            input logic eh, input logic ed);
    @(negedge clk);
    enable = 1'b1; write = 1'b0; addr = s; tag = t;
    #1;
    chk({name, "_hit"}, {255'd0, hit}, {255'd0, eh});
    chk({name, "_dirty"}, {255'd0, dirty}, {255'd0, ed});
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
  endtask

  task automatic do_op(input logic wr, input logic [3:0] s, input logic [22:0] t,
                       input logic [255:0] d, input logic dr);
    @(negedge clk);
    enable = 1'b1; write = wr; addr = s; tag = t; wdata = d; dirty_in = dr;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0; write = 1'b0; dirty_in = 1'b0;
  endtask

  initial begin
    int n, hs0, dn0;
    rst_n = 1'b0; enable = 1'b0; write = 1'b0; dirty_in = 1'b0; addr = '0;
    tag = '0; wdata = '0; flush = 1'b0; wb_ready = 1'b0; stats_clr = 1'b0;

    // Set 3 refills, then a hit
    vecs.push_back(wr_empty(4'd3, 23'h10, 8'd1, 1'b0));
    vecs.push_back(wr_empty(4'd3, 23'h11, 8'd1, 1'b0));
    vecs.push_back(wr_empty(4'd3, 23'h12, 8'd1, 1'b0));
    vecs.push_back(wr_empty(4'd3, 23'h13, 8'd1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd3, 23'h12, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 23'h12, mkd(23'h12, 8'd1)));
    // Set 5: fill, touch ways 0..2, victim is way 3
    vecs.push_back(wr_empty(4'd5, 23'h50, 8'd1, 1'b0));
    vecs.push_back(wr_empty(4'd5, 23'h51, 8'd1, 1'b0));
    vecs.push_back(wr_empty(4'd5, 23'h52, 8'd1, 1'b0));
    vecs.push_back(wr_empty(4'd5, 23'h53, 8'd1, 1'b0));
    vecs.push_back(mk(1'b0, 4'd5, 23'h50, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 23'h50, mkd(23'h50, 8'd1)));
    vecs.push_back(mk(1'b0, 4'd5, 23'h51, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 23'h51, mkd(23'h51, 8'd1)));
    vecs.push_back(mk(1'b0, 4'd5, 23'h52, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 23'h52, mkd(23'h52, 8'd1)));
    vecs.push_back(mk(1'b0, 4'd5, 23'h99, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 23'h53, mkd(23'h53, 8'd1)));
    vecs.push_back(mk(1'b1, 4'd5, 23'h99, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 23'h53, mkd(23'h53, 8'd1)));
    vecs.push_back(mk(1'b0, 4'd5, 23'h99, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 23'h99, mkd(23'h99, 8'd1)));
    vecs.push_back(mk(1'b0, 4'd5, 23'h53, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 23'h50, mkd(23'h50, 8'd1)));
    // Set 7: store to way 0, age it out, refill over the dirty victim
    vecs.push_back(wr_empty(4'd7, 23'h70, 8'd1, 1'b0));
    vecs.push_back(wr_empty(4'd7, 23'h71, 8'd1, 1'b0));
    vecs.push_back(wr_empty(4'd7, 23'h72, 8'd1, 1'b0));
    vecs.push_back(wr_empty(4'd7, 23'h73, 8'd1, 1'b0));
    vecs.push_back(mk(1'b1, 4'd7, 23'h70, 8'd2, 1'b1, 1'b1, 1'b1, 1'b0, 23'h70, mkd(23'h70, 8'd1)));
    vecs.push_back(mk(1'b0, 4'd7, 23'h71, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 23'h71, mkd(23'h71, 8'd1)));
    vecs.push_back(mk(1'b0, 4'd7, 23'h72, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 23'h72, mkd(23'h72, 8'd1)));
    vecs.push_back(mk(1'b0, 4'd7, 23'h73, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 23'h73, mkd(23'h73, 8'd1)));
    vecs.push_back(mk(1'b0, 4'd7, 23'h7A, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 23'h70, mkd(23'h70, 8'd2)));
    vecs.push_back(mk(1'b1, 4'd7, 23'h7A, 8'd1, 1'b0, 1'b0, 1'b1, 1'b1, 23'h70, mkd(23'h70, 8'd2)));
    vecs.push_back(mk(1'b0, 4'd7, 23'h7A, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 23'h7A, mkd(23'h7A, 8'd1)));
    // Dirty lines at set 0 way 1 and set 15 way 3
    vecs.push_back(wr_empty(4'd0, 23'h100, 8'd1, 1'b0));
    vecs.push_back(wr_empty(4'd0, 23'h101, 8'd3, 1'b1));
    vecs.push_back(mk(1'b0, 4'd0, 23'h101, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 23'h101, mkd(23'h101, 8'd3)));
    vecs.push_back(wr_empty(4'd15, 23'hF0, 8'd1, 1'b0));
    vecs.push_back(wr_empty(4'd15, 23'hF1, 8'd1, 1'b0));
    vecs.push_back(wr_empty(4'd15, 23'hF2, 8'd1, 1'b0));
    vecs.push_back(wr_empty(4'd15, 23'hF3, 8'd3, 1'b1));
    vecs.push_back(mk(1'b0, 4'd15, 23'hF3, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1, 23'hF3, mkd(23'hF3, 8'd3)));

    // Reset state
    #1;
    chk("rst_hit", {255'd0, hit}, 256'd0);
    chk("rst_valid", {255'd0, valid}, 256'd0);
    chk("rst_tag", {233'd0, tag_out}, 256'd0);
    chk("rst_data", data_out, 256'd0);
    chk("rst_busy", {255'd0, busy}, 256'd0);
    chk("rst_wb_valid", {255'd0, wb_valid}, 256'd0);
    chk("rst_done", {255'd0, flush_done}, 256'd0);
    chk("rst_cnt", {192'd0, hit_cnt, miss_cnt}, 256'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      enable = 1'b1; write = vecs[i].wr; addr = vecs[i].set; tag = vecs[i].tag;
      wdata = vecs[i].data; dirty_in = vecs[i].dirty;
      #1;
      chk($sformatf("v%0d_hit", i), {255'd0, hit}, {255'd0, vecs[i].e_hit});
      chk($sformatf("v%0d_valid", i), {255'd0, valid}, {255'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_dirty", i), {255'd0, dirty}, {255'd0, vecs[i].e_dirty});
      chk($sformatf("v%0d_tag", i), {233'd0, tag_out}, {233'd0, vecs[i].e_tag});
      chk($sformatf("v%0d_data", i), data_out, vecs[i].e_data);
      @(posedge clk);
    end
    @(negedge clk);
    enable = 1'b0; write = 1'b0; dirty_in = 1'b0;

    // Flush with two dirty lines and a stalled sink
    hs0 = hs_cnt; dn0 = done_cnt;
    flush = 1'b1; wb_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    wait_wb(n);
    chk("first_wb_latency", n, 3);
    for (int i = 0; i < 4; i++) begin
      chk("wb1_valid_held", {255'd0, wb_valid}, 256'd1);
      chk("wb1_set", {252'd0, wb_set}, 256'd0);
      chk("wb1_tag", {233'd0, wb_tag}, {233'd0, 23'h101});
      chk("wb1_data", wb_data, mkd(23'h101, 8'd3));
      chk("busy_in_wb", {255'd0, busy}, 256'd1);
      if (i == 1) begin
        enable = 1'b1; write = 1'b0; addr = 4'd3; tag = 23'h12;
        #1;
        chk("busy_lookup_hit", {255'd0, hit}, 256'd0);
        enable = 1'b0;
      end
      @(negedge clk); #1;
    end
    wb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wb_ready = 1'b0;
    #1;
    wait_wb(n);
    chk("wb2_set", {252'd0, wb_set}, 256'd15);
    chk("wb2_tag", {233'd0, wb_tag}, {233'd0, 23'hF3});
    chk("wb2_data", wb_data, mkd(23'hF3, 8'd3));
    wb_ready = 1'b1;
    wait_idle(n);
    wb_ready = 1'b0;
    chk("flush1_handshakes", hs_cnt - hs0, 2);
    chk("flush1_done_pulses", done_cnt - dn0, 1);
    lookup_chk("clean_s0", 4'd0, 23'h101, 1'b1, 1'b0);
    lookup_chk("clean_s15", 4'd15, 23'hF3, 1'b1, 1'b0);

    // Flush started together with a dirty write: the walk must include it
    hs0 = hs_cnt;
    enable = 1'b1; write = 1'b1; dirty_in = 1'b1; addr = 4'd9; tag = 23'h90;
    wdata = mkd(23'h90, 8'd4); flush = 1'b1; wb_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0; write = 1'b0; dirty_in = 1'b0; flush = 1'b0;
    #1;
    wait_idle(n);
    wb_ready = 1'b0;
    chk("flush2_handshakes", hs_cnt - hs0, 1);
    chk("flush2_wb_set", {252'd0, last_set}, 256'd9);
    chk("flush2_wb_tag", {233'd0, last_tag}, {233'd0, 23'h90});
    lookup_chk("clean_s9", 4'd9, 23'h90, 1'b1, 1'b0);

    // Clean-cache walk length: SETS*WAYS scan cycles plus one done cycle
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    n = 1;
    while (!flush_done && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    chk("clean_walk_cycles", n, 65);
    @(negedge clk); #1;
    chk("clean_walk_idle", {255'd0, busy}, 256'd0);

    // Reset asserted in the middle of a writeback
    do_op(1'b1, 4'd4, 23'h44, mkd(23'h44, 8'd5), 1'b1);
    flush = 1'b1; wb_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    wait_wb(n);
    chk("rwb_set", {252'd0, wb_set}, 256'd4);
    rst_n = 1'b0;
    #1;
    chk("rwb_wb_valid", {255'd0, wb_valid}, 256'd0);
    chk("rwb_busy", {255'd0, busy}, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1; write = 1'b0; addr = 4'd4; tag = 23'h44;
    #1;
    chk("rwb_lookup_hit", {255'd0, hit}, 256'd0);
    enable = 1'b0;

    // Statistics: 3 hits, 2 misses, then clear with a coincident hit
    do_op(1'b1, 4'd1, 23'h1A, mkd(23'h1A, 8'd6), 1'b0);
    @(negedge clk);
    enable = 1'b1; write = 1'b0; addr = 4'd1;
    tag = 23'h1A; @(posedge clk); @(negedge clk);
    tag = 23'h1B; @(posedge clk); @(negedge clk);
    tag = 23'h1A; @(posedge clk); @(negedge clk);
    tag = 23'h1C; @(posedge clk); @(negedge clk);
    tag = 23'h1A; @(posedge clk); @(negedge clk);
    enable = 1'b0;
    #1;
`ifdef DCACHE_SRAM_STATS_EN
    chk("stats_hits", {224'd0, hit_cnt}, 256'd3);
    chk("stats_misses", {224'd0, miss_cnt}, 256'd2);
`else
    chk("stats_hits", {224'd0, hit_cnt}, 256'd0);
    chk("stats_misses", {224'd0, miss_cnt}, 256'd0);
`endif
    @(negedge clk);
    enable = 1'b1; write = 1'b0; addr = 4'd1; tag = 23'h1A; stats_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0; stats_clr = 1'b0;
    #1;
    chk("stats_clr_hits", {224'd0, hit_cnt}, 256'd0);
    chk("stats_clr_misses", {224'd0, miss_cnt}, 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
